parking_occupancy_tracker: RTL
==============================

// Module: parking_occupancy_tracker
// PURPOSE
//  Source side of the lot's occupancy interface: turns entry/exit gate requests into the
//  registered 'parked' count, which the zeros_counter stage turns into 'empty' for display.
//  Arbitrates the two gates, drives a timed gate-open pulse and refuses entry when full.
//  One instance per lot; sits between the gate sensors and the display logic.
// PARAMETERS
//  CNT_W          3   width of parked/empty counts
//  CAPACITY       7   number of spaces; 1 <= CAPACITY <= 2**CNT_W-1
//  GATE_CYCLES    4   cycles a gate stays open per granted car (>=1)
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      asynchronous, active-high; clears all state
//  entry_req      in   1      car waiting at entry sensor (level; held until granted)
//  exit_req       in   1      car waiting at exit sensor (level; held until granted)
//  entry_gate     out  1      entry barrier open
//  exit_gate      out  1      exit barrier open
//  entry_denied   out  1      1-cycle pulse: entry refused, lot full
//  parked         out  CNT_W  cars currently inside (registered)
//  empty          out  CNT_W  CAPACITY - parked (registered, same cycle as parked)
//  full           out  1      parked == CAPACITY
// BEHAVIOUR
//  Reset (async, active-high): state IDLE, parked=0, empty=CAPACITY, full=0,
//   both gates 0, entry_denied=0, timer=0. Asserting reset mid-open closes gates immediately.
//  FSM states: IDLE, ENTRY_OPEN, EXIT_OPEN, COOLDOWN.
//  IDLE, evaluated on each clk edge:
//   - exit_req && parked!=0 -> EXIT_OPEN; parked-1, empty+1 on that edge.
//   - else entry_req && !full -> ENTRY_OPEN; parked+1, empty-1 on that edge.
//   - else entry_req && full -> entry_denied=1 for one cycle; stay IDLE. Re-pulses every
//     4th cycle while entry_req is held and the lot stays full (rate limit via timer).
//   - exit_req with parked==0: ignored (sensor fault), no count change.
//   - Both requests in the same cycle: exit wins (frees a space); entry is served next.
//  ENTRY_OPEN / EXIT_OPEN: matching gate=1 for exactly GATE_CYCLES cycles, starting the cycle
//   after the grant edge; requests ignored; then -> COOLDOWN.
//  COOLDOWN: 1 cycle, both gates 0 (barrier settle); -> IDLE. The requester must drop its
//   req before IDLE, or it is granted again as a new car.
//  Latency: req sampled high in IDLE -> count updates on that edge; gate opens next cycle.
//   Grant-to-grant minimum is GATE_CYCLES+2 cycles.
//  Counts: parked never wraps; saturates at 0 and CAPACITY by construction (guards above).
//   empty is a registered CNT_W-bit value with no borrow out; invariant parked+empty==CAPACITY
//   holds every cycle. full is derived from the registered parked value.
//  Gates are mutually exclusive; entry_gate&&exit_gate is never 1.
// STRUCTURE
//  Shared package/header: FSM state encoding (2-bit), DENY_RATE=4, default CAPACITY/CNT_W.
//  One sub-module: gate_timer (load, count-down, done) for the open interval and the deny
//   rate limit; count/FSM logic stays in this module.
//  Verify empty against the zeros_counter output (when CAPACITY == 2**CNT_W-1) as a cross-check.
// TESTING
//  1 reset high mid-ENTRY_OPEN, parked=3 -> gates 0 at once; after release parked=0, empty=7.
//  2 seven single entries (req high 1 cycle, each waits out the gate) -> parked 1..7, each gate
//    pulse 4 cycles wide, full=1 after the 7th grant, empty=0.
//  3 full lot, entry_req held 12 cycles -> entry_denied pulses at cycles 0,4,8; parked stays 7.
//  4 parked=3, entry_req and exit_req high in the same cycle -> exit_gate first, parked=2;
//    after COOLDOWN, entry granted, parked=3.
//  5 parked=0, exit_req held -> no gate, no count change, no underflow (parked stays 0).
//  6 random req streams for 10k cycles -> gates never both high; parked+empty==7 every cycle;
//    parked in [0,7].

Source files
------------

// File: rtl/parking_occupancy_tracker_pkg.sv
// Shared types and constants for the parking occupancy tracker.
// Holds the FSM state encoding, the deny rate limit and the default lot sizing.
package parking_occupancy_tracker_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StEntryOpen = 2'd1,
    StExitOpen  = 2'd2,
    StCooldown  = 2'd3
  } state_e;

  // A refused car sees entry_denied once every DENY_RATE cycles while it keeps requesting.
  localparam int unsigned DENY_RATE        = 4;
  localparam int unsigned DEFAULT_CNT_W    = 3;
  localparam int unsigned DEFAULT_CAPACITY = 7;
  localparam int unsigned DEFAULT_GATE_CYC = 4;

  // Width needed to hold values 0..max_val-1, never narrower than one bit.
  function automatic int unsigned timer_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/parking_occupancy_tracker_gate_timer.sv
// Loadable down-counter shared by the gate-open interval and the deny rate limit.
// Counts down to zero and holds there; done is high whenever the count is zero.
module parking_occupancy_tracker_gate_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/parking_occupancy_tracker.sv
// Lot occupancy tracker: arbitrates entry/exit gates, times the gate-open pulse and keeps
// the registered parked/empty counts, refusing (rate-limited) entry while the lot is full.
module parking_occupancy_tracker
  import parking_occupancy_tracker_pkg::*;
#(
  parameter int unsigned CNT_W       = DEFAULT_CNT_W,
  parameter int unsigned CAPACITY    = DEFAULT_CAPACITY,
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             entry_denied,
  output logic [CNT_W-1:0] parked,
  output logic [CNT_W-1:0] empty,
  output logic             full
);

  localparam int unsigned TimerMax = (GATE_CYCLES > DENY_RATE) ? GATE_CYCLES : DENY_RATE;
  localparam int unsigned TimerW   = timer_width(TimerMax);

  // Loaded with N-1 so the timer is done on the Nth cycle in the open/wait state.
  localparam logic [TimerW-1:0] GateLoad = TimerW'(GATE_CYCLES - 1);
  localparam logic [TimerW-1:0] DenyLoad = TimerW'(DENY_RATE - 1);
  localparam logic [CNT_W-1:0]  Cap      = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  parked_q, parked_d;
  logic [CNT_W-1:0]  empty_q, empty_d;
  logic              deny_q, deny_d;
  logic              full_w;
  logic              tmr_load;
  logic [TimerW-1:0] tmr_val;
  logic              tmr_done;

  assign full_w = (parked_q == Cap);

  parking_occupancy_tracker_gate_timer #(
    .W (TimerW)
  ) u_gate_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    parked_d = parked_q;
    empty_d  = empty_q;
    deny_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      StIdle: begin
        // Exit has priority: it frees a space the waiting entry may then take.
        if (exit_req && (parked_q != '0)) begin
          state_d  = StExitOpen;
          parked_d = parked_q - CntOne;
          empty_d  = empty_q + CntOne;
          tmr_load = 1'b1;
          tmr_val  = GateLoad;
        end else if (entry_req && !full_w) begin
          state_d  = StEntryOpen;
          parked_d = parked_q + CntOne;
          empty_d  = empty_q - CntOne;
          tmr_load = 1'b1;
          tmr_val  = GateLoad;
        end else if (entry_req && tmr_done) begin
          deny_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = DenyLoad;
        end
      end
      StEntryOpen, StExitOpen: begin
        if (tmr_done) begin
          state_d = StCooldown;
        end
      end
      StCooldown: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      parked_q <= '0;
      empty_q  <= Cap;
      deny_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parked_q <= parked_d;
      empty_q  <= empty_d;
      deny_q   <= deny_d;
    end
  end

  // Gates decode straight from the state register so reset closes them without waiting.
  assign entry_gate   = (state_q == StEntryOpen);
  assign exit_gate    = (state_q == StExitOpen);
  assign entry_denied = deny_q;
  assign parked       = parked_q;
  assign empty        = empty_q;
  assign full         = full_w;

endmodule
